// File: rtl/cv32e40p_ft_replica_manager.sv
// Fault-tolerant replica manager: mismatch counting, TMR set selection, drain handshake.
// Define FT_ERR_DECAY_EN to let clean voting events slowly decay the mismatch counters.
module cv32e40p_ft_replica_manager #(
    parameter int N_REPLICA       = 4,
    parameter int CNT_WIDTH       = 4,
    parameter int FAULT_THRESHOLD = 8,
    parameter int IDX_W           = $clog2(N_REPLICA),
    parameter int DECAY_PERIOD    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 err_valid_i,
    input  logic [N_REPLICA-1:0] err_replica_i,
    input  logic [N_REPLICA-1:0] force_fault_i,
    output logic                 reconf_req_o,
    input  logic                 reconf_ack_i,
    output logic [N_REPLICA-1:0] active_mask_o,
    output logic [3*IDX_W-1:0]   slot_idx_o,
    output logic [N_REPLICA-1:0] fault_o,
    output logic                 degraded_o,
    output logic                 reconf_done_o
);

    typedef enum logic [1:0] {IDLE, REQ, APPLY} state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_THR  = CNT_WIDTH'(FAULT_THRESHOLD);
    localparam logic [N_REPLICA-1:0] RST_MASK = N_REPLICA'(3'b111);
    localparam logic [3*IDX_W-1:0]   RST_SLOT = {IDX_W'(2), IDX_W'(1), IDX_W'(0)};

    logic [CNT_WIDTH-1:0] cnt_q [N_REPLICA];
    logic [CNT_WIDTH-1:0] cnt_d [N_REPLICA];
    logic [N_REPLICA-1:0] fault_q, fault_d;
    logic [N_REPLICA-1:0] mask_q, mask_d;
    logic [3*IDX_W-1:0]   slot_q, slot_d;
    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic                 deg_q, deg_d;

    logic [N_REPLICA-1:0] tgt_mask;
    logic [3*IDX_W-1:0]   tgt_slot;
    logic                 tgt_deg;

`ifdef FT_ERR_DECAY_EN
    localparam int CLN_W = $clog2(DECAY_PERIOD + 1);
    localparam logic [CLN_W-1:0] CLN_LAST = CLN_W'(DECAY_PERIOD - 1);

    logic [CLN_W-1:0] clean_q [N_REPLICA];
    logic [CLN_W-1:0] clean_d [N_REPLICA];
`endif

    // Three lowest-indexed healthy replicas; hold the current set when degraded.
    always_comb begin
        int found;
        found    = 0;
        tgt_mask = '0;
        tgt_slot = '0;
        for (int i = 0; i < N_REPLICA; i++) begin
            if (!fault_q[i] && found < 3) begin
                tgt_slot[found*IDX_W +: IDX_W] = IDX_W'(i);
                tgt_mask[i] = 1'b1;
                found++;
            end
        end
        tgt_deg = (found < 3);
        if (tgt_deg) begin
            tgt_mask = mask_q;
            tgt_slot = slot_q;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REPLICA; i++) begin
            cnt_d[i] = cnt_q[i];
`ifdef FT_ERR_DECAY_EN
            clean_d[i] = clean_q[i];
`endif
            if (!fault_q[i] && err_valid_i) begin
                if (err_replica_i[i]) begin
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
`ifdef FT_ERR_DECAY_EN
                    clean_d[i] = '0;
`endif
                end
`ifdef FT_ERR_DECAY_EN
                else if (clean_q[i] == CLN_LAST) begin
                    clean_d[i] = '0;
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end else begin
                    clean_d[i] = clean_q[i] + 1'b1;
                end
`endif
            end
            fault_d[i] = fault_q[i] | force_fault_i[i] | (cnt_q[i] >= CNT_THR);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        slot_d  = slot_q;
        unique case (state_q)
            IDLE: begin
                if (!tgt_deg && tgt_slot != slot_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (reconf_ack_i) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = IDLE;
                mask_d  = tgt_mask;
                slot_d  = tgt_slot;
            end
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == REQ);
        done_d = (state_q == APPLY);
        deg_d  = tgt_deg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REPLICA; i++) begin
                cnt_q[i] <= '0;
`ifdef FT_ERR_DECAY_EN
                clean_q[i] <= '0;
`endif
            end
            fault_q <= '0;
            mask_q  <= RST_MASK;
            slot_q  <= RST_SLOT;
            state_q <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            deg_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_REPLICA; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef FT_ERR_DECAY_EN
                clean_q[i] <= clean_d[i];
`endif
            end
            fault_q <= fault_d;
            mask_q  <= mask_d;
            slot_q  <= slot_d;
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            deg_q   <= deg_d;
        end
    end

    assign reconf_req_o  = req_q;
    assign active_mask_o = mask_q;
    assign slot_idx_o    = slot_q;
    assign fault_o       = fault_q;
    assign degraded_o    = deg_q;
    assign reconf_done_o = done_q;

endmodule

// File: tb/tb_cv32e40p_ft_replica_manager.sv
// Directed vector bench for the replica manager (N=4, threshold 3, decay period 4).
module tb_cv32e40p_ft_replica_manager;

    typedef struct {
        logic       rst;
        logic       ev;
        logic [3:0] err;
        logic [3:0] frc;
        logic       ack;
        logic       req;
        logic [3:0] mask;
        logic [5:0] slot;
        logic [3:0] flt;
        logic       deg;
        logic       done;
    } vec_t;

    localparam logic [5:0] SR = 6'b10_01_00;
    localparam logic [5:0] SS = 6'b11_10_00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_valid;
    logic [3:0] err_rep;
    logic [3:0] force_f;
    logic       ack;
    logic       req;
    logic [3:0] mask;
    logic [5:0] slot;
    logic [3:0] fault;
    logic       deg;
    logic       done;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    cv32e40p_ft_replica_manager #(
        .N_REPLICA      (4),
        .CNT_WIDTH      (4),
        .FAULT_THRESHOLD(3),
        .DECAY_PERIOD   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_valid_i  (err_valid),
        .err_replica_i(err_rep),
        .force_fault_i(force_f),
        .reconf_req_o (req),
        .reconf_ack_i (ack),
        .active_mask_o(mask),
        .slot_idx_o   (slot),
        .fault_o      (fault),
        .degraded_o   (deg),
        .reconf_done_o(done)
    );

    function automatic vec_t mk(
        input logic r, input logic e, input logic [3:0] er,
        input logic [3:0] f, input logic a, input logic rq,
        input logic [3:0] m, input logic [5:0] s,
        input logic [3:0] fl, input logic d, input logic dn);
        vec_t v;
        v.rst = r; v.ev = e; v.err = er; v.frc = f; v.ack = a;
        v.req = rq; v.mask = m; v.slot = s; v.flt = fl;
        v.deg = d; v.done = dn;
        return v;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] er,
                         input logic [3:0] f, input logic a);
        @(negedge clk);
        rst_n     = r;
        err_valid = e;
        err_rep   = er;
        force_f   = f;
        ack       = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_flt;
        rst_n = 1'b0; err_valid = 1'b0; err_rep = '0; force_f = '0; ack = 1'b0;

        // reset, then replica 1 faults with ack tied high
        tbl.push_back(mk(0,0,4'h0,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(0,0,4'h0,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h2,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h2,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h2,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h2,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 1,4'h7,SR,4'h2,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h2,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'hd,SS,4'h2,0,1));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'hd,SS,4'h2,0,0));
        // spare replica 3 forced faulty
        tbl.push_back(mk(0,0,4'h0,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h8,1, 0,4'h7,SR,4'h8,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h8,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h8,0,0));
        // fault during REQ turns the set degraded
        tbl.push_back(mk(0,0,4'h0,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h1,0, 0,4'h7,SR,4'h1,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 1,4'h7,SR,4'h1,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h4,0, 1,4'h7,SR,4'h5,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 1,4'h7,SR,4'h5,1,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h5,1,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 0,4'h7,SR,4'h5,1,1));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 0,4'h7,SR,4'h5,1,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 0,4'h7,SR,4'h5,1,0));
        // reset mid-handshake clears counters and aborts the apply
        tbl.push_back(mk(0,0,4'h0,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h1,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h1,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h1,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 0,4'h7,SR,4'h1,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,0, 1,4'h7,SR,4'h1,0,0));
        tbl.push_back(mk(0,0,4'h0,4'h0,0, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h1,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,1,4'h1,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h0,0,0));
        tbl.push_back(mk(1,0,4'h0,4'h0,1, 0,4'h7,SR,4'h0,0,0));

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].ev, tbl[k].err, tbl[k].frc, tbl[k].ack);
            chk($sformatf("row%0d", k),
                32'({req, mask, slot, fault, deg, done}),
                32'({tbl[k].req, tbl[k].mask, tbl[k].slot,
                     tbl[k].flt, tbl[k].deg, tbl[k].done}));
        end

        // two mismatches, eight clean events, two more mismatches on replica 2
        drive(0, 0, 4'h0, 4'h0, 0);
        for (int j = 0; j < 2; j++) drive(1, 1, 4'h4, 4'h0, 0);
        for (int j = 0; j < 8; j++) drive(1, 1, 4'h0, 4'h0, 0);
        for (int j = 0; j < 2; j++) drive(1, 1, 4'h4, 4'h0, 0);
        drive(1, 0, 4'h0, 4'h0, 0);
`ifdef FT_ERR_DECAY_EN
        exp_flt = 4'h0;
`else
        exp_flt = 4'h4;
`endif
        chk("decay_fault", 32'(fault), 32'(exp_flt));
        chk("decay_mask", 32'(mask), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
